// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and byte-lane helpers for the dmem_bank data memory.
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       we;
    size_e      size;
    logic       uns;
    logic [2:0] off;
  } meta_t;

  function automatic logic [7:0] lane_mask(input size_e size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Double accesses only exist on a 64-bit bank.
  function automatic logic misaligned(input size_e size, input logic [2:0] off, input logic wide);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off[1:0];
      default: bad = ~wide | (|off);
    endcase
    return bad;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] word, input size_e size,
                                              input logic [2:0] off, input logic uns);
    logic [63:0] s;
    logic [63:0] r;
    s = word >> {off, 3'b000};
    case (size)
      SZ_B:    r = {{56{~uns & s[7]}}, s[7:0]};
      SZ_H:    r = {{48{~uns & s[15]}}, s[15:0]};
      SZ_W:    r = {{32{~uns & s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with per-byte write enables and registered read.
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic                  clk_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [1 << IDX_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_bank.sv
// dmem_bank: handshaked data-memory bank with sized/extended accesses, alignment
// errors, pipelined read latency and a hardware zero-clear sequence.
`default_nettype none

module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  output logic              busy_o,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = ADDR_W - OFF_W;

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              busy_q;
  logic              ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_i) begin
            cnt_q <= '0;
          end else if (&cnt_q) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (clr_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign req_ready_o = ready_q;

  logic              accept;
  size_e             req_size;
  logic [2:0]        req_off;
  logic              req_err;
  logic [7:0]        lane_all;
  logic [IDX_W-1:0]  ram_addr;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign accept   = req_valid_i & ready_q;
  assign req_size = size_e'(req_size_i);
  assign req_off  = 3'(req_addr_i[OFF_W-1:0]);
  assign req_err  = misaligned(req_size, req_off, DATA_W == 64);
  assign lane_all = lane_mask(req_size, req_off);

  // The clear sequence owns the single RAM port; requests are only accepted in RUN.
  always_comb begin
    ram_addr  = req_addr_i[ADDR_W-1:OFF_W];
    ram_be    = '0;
    ram_wdata = req_wdata_i << {req_off, 3'b000};
    if (state_q == CLEAR) begin
      ram_addr  = cnt_q;
      ram_be    = '1;
      ram_wdata = '0;
    end else if (accept && req_we_i && !req_err) begin
      ram_be = lane_all[NB-1:0];
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .addr_i  (ram_addr),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  meta_t meta_d;
  meta_t meta_q [READ_LAT];

  always_comb begin
    meta_d       = '0;
    meta_d.valid = accept;
    meta_d.err   = req_err;
    meta_d.we    = req_we_i;
    meta_d.size  = req_size;
    meta_d.uns   = req_unsigned_i;
    meta_d.off   = req_off;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < READ_LAT; i++) meta_q[i] <= '0;
    end else begin
      meta_q[0] <= meta_d;
      for (int i = 1; i < READ_LAT; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  // RAM output register is itself the first data stage, aligned with meta_q[0].
  logic [DATA_W-1:0] rd_last;

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign rd_last = ram_rdata;
    end else begin : g_latn
      logic [DATA_W-1:0] rd_q [READ_LAT-1];
      always_ff @(posedge clk_i) begin
        rd_q[0] <= ram_rdata;
        for (int i = 1; i < READ_LAT - 1; i++) rd_q[i] <= rd_q[i-1];
      end
      assign rd_last = rd_q[READ_LAT-2];
    end
  endgenerate

  meta_t       tail;
  logic [63:0] ext_all;
  logic        unused_bits;

  assign tail        = meta_q[READ_LAT-1];
  assign ext_all     = load_extend(64'(rd_last), tail.size, tail.off, tail.uns);
  assign unused_bits = ^{lane_all, ext_all};

  assign rsp_valid_o = tail.valid;
  assign rsp_err_o   = tail.valid & tail.err;
  assign rsp_rdata_o = (tail.valid && !tail.err && !tail.we) ? ext_all[DATA_W-1:0] : '0;

endmodule

`default_nettype wire

// File: doc/dmem_bank.md
# dmem_bank

Parametrised data-memory bank that replaces the fixed 32-bit, single-cycle data RAM on the CORE's data port. It adds a valid/ready request handshake, byte/half/word(/double) access sizes with sign or zero extension, misalignment errors, a configurable pipelined read latency, and a hardware zero-clear sequence after reset or on demand. It sits between the CORE load/store unit and the on-chip data storage; instruction ROM is unaffected.

## Interface
- DATA_W, 32, bank word width; 32 or 64 only
- ADDR_W, 12, byte-address width; DEPTH = 2^(ADDR_W − log2(DATA_W/8)) words
- READ_LAT, 2, request-to-response latency in cycles; 1..4
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- clr  in  1  one-cycle pulse: restart zero-clear of whole array
- busy  out  1  high while clear sequence runs
- req_valid  in  1  request present
- req_ready  out  1  request accepted on edge where valid & ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (legal only if DATA_W=64)
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  DATA_W  store data, right-aligned (low bits)
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  load data, right-aligned and extended; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid

## Operation
- FSM states CLEAR, RUN. reset → CLEAR with counter 0.
- CLEAR: write 0 to word[counter] each cycle, counter++; after writing DEPTH−1 → RUN. req_ready=0, busy=1.
- RUN: req_ready=1, busy=0. clr in RUN → CLEAR next cycle, counter 0. clr in CLEAR → counter restarts at 0.
- Word index = req_addr[ADDR_W−1:log2(DATA_W/8)]; lane offset = low bits.
- Misaligned: address not a multiple of 2^size; size 3 with DATA_W=32 is illegal. Either → no array write, error response.
- Store: lane-enable mask = (2^(2^size) − 1) << offset; req_wdata shifted left by offset·8; only enabled bytes written.
- Load: word read, shifted right by offset·8, truncated to 8·2^size bits, extended per req_unsigned.
- Every accepted request (load, store or error) yields exactly one response, in order.
- No response backpressure; one request per cycle sustained in RUN.

## Timing
- Reset values: req_ready 0, busy 1 (CLEAR entered), rsp_valid 0, rsp_rdata 0, rsp_err 0; all pipeline valid bits 0. Array contents not reset — cleared by FSM (DEPTH cycles).
- Request accepted at edge E → store written at E; rsp_valid high for the cycle following edge E+READ_LAT−1 (i.e. visible after READ_LAT edges).
- Load at E+1 of a store to the same word at E returns new data.
- Pipeline of READ_LAT stages carries valid, err, size, unsigned, offset; extension applied in final stage.
- Responses in flight when clr fires are still delivered; clear writes start the cycle after clr.
- reset asserted mid-operation: rsp_valid drops immediately (async), in-flight responses discarded, clear reruns on release.

## Structure
- dmem_pkg: size enum (SZ_B, SZ_H, SZ_W, SZ_D), state enum (CLEAR, RUN), functions for lane mask, misalignment check, load extension.
- Sub-module dmem_array: plain single-port synchronous RAM, DEPTH × DATA_W, per-byte write enables, registered read. Top holds FSM, clear counter, request decode, response pipeline.

## Test plan
(DATA_W=32, ADDR_W=12, READ_LAT=2 unless noted)
- Reset release → busy=1, req_ready=0 for exactly 1024 cycles, then ready; load word 0x000 → rsp_rdata 0x00000000, 2 cycles after accept.
- Store word 0xDEADBEEF @0x010; load byte signed @0x011 → 0xFFFFFFBE; unsigned → 0x000000BE; half unsigned @0x012 → 0x0000DEAD.
- Store word 0x11223344 @0x020, store byte 0xAA @0x021; load word → 0x1122AA44.
- Store half 0xFFFF @0x013 → rsp_err=1, rsp_rdata 0; load word @0x010 still 0xDEADBEEF; size 3 at DATA_W=32 → rsp_err=1.
- 8 back-to-back loads of 0x000..0x01C → 8 consecutive rsp_valid cycles, in order; repeat with READ_LAT=4 and DATA_W=64 (double @0x008 aligned ok, @0x004 err).
- clr with 2 loads in flight → both responses delivered, then 1024 busy cycles, old data reads 0; reset with 2 in flight → no responses, clear reruns.
